// File: rtl/key_debounce_if.sv
// Signal bundle for key_debounce_array: raw key inputs, the shared count
// enable and the conditioned per-channel outputs.
// There is no valid/ready handshake on this bundle. key_i and tick are
// levels sampled on every clk. key_o is a level. press_p, release_p and
// hold_p are one-clk strobes that need no acknowledgement.
interface key_debounce_if #(
    parameter int CHANNELS = 5
);
    logic                tick;
    logic [CHANNELS-1:0] key_i;
    logic [CHANNELS-1:0] key_o;
    logic [CHANNELS-1:0] press_p;
    logic [CHANNELS-1:0] release_p;
    logic [CHANNELS-1:0] hold_p;

    modport master (
        output tick, key_i,
        input  key_o, press_p, release_p, hold_p
    );

    modport slave (
        input  tick, key_i,
        output key_o, press_p, release_p, hold_p
    );
endinterface

// File: rtl/key_debounce_array.sv
// Multi-channel button/switch conditioner. Each channel has a 2-FF
// synchroniser and a stability-count debounce that produces the level
// key_o. It also produces one-clk press/release strobes and a hold strobe
// after a long press, with optional auto-repeat. The tick input gates the
// counters so that one shared prescaler can keep them narrow.
module key_debounce_array #(
    parameter int CHANNELS      = 5,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int CNT_W         = 24,
    parameter int HOLD_CYCLES   = 20_000_000,
    parameter int REPEAT_CYCLES = 0,
    parameter int HOLD_W        = 26,
    parameter int ACTIVE_LOW    = 0
) (
    input logic           clk,
    input logic           reset,
    key_debounce_if.slave bus
);

    // Reject parameter sets where a counter would have to wrap.
    if (CHANNELS < 1) begin : g_bad_channels
        $error("key_debounce_array: CHANNELS must be >= 1");
    end
    if (STABLE_CYCLES < 1 || (64'(STABLE_CYCLES) >> CNT_W) != 0) begin : g_bad_stable
        $error("key_debounce_array: STABLE_CYCLES must be >= 1 and fit in CNT_W bits");
    end
    if (HOLD_CYCLES < 1 || (64'(HOLD_CYCLES) >> HOLD_W) != 0) begin : g_bad_hold
        $error("key_debounce_array: HOLD_CYCLES must be >= 1 and fit in HOLD_W bits");
    end
    if (REPEAT_CYCLES < 0 || (64'(REPEAT_CYCLES) >> HOLD_W) != 0) begin : g_bad_repeat
        $error("key_debounce_array: REPEAT_CYCLES must be >= 0 and fit in HOLD_W bits");
    end

    localparam logic [CNT_W-1:0]    STABLE_C = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]    ONE_C    = CNT_W'(1);
    localparam logic [HOLD_W-1:0]   HOLD_C   = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]   REPEAT_C = HOLD_W'(REPEAT_CYCLES);
    localparam logic [HOLD_W-1:0]   ONE_H    = HOLD_W'(1);
    localparam logic [CHANNELS-1:0] INV_MASK = {CHANNELS{ACTIVE_LOW != 0}};

    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CHANNELS-1:0] cand;
    logic [CHANNELS-1:0] key_q;
    logic [CHANNELS-1:0] press_q;
    logic [CHANNELS-1:0] release_q;
    logic [CHANNELS-1:0] hold_q;
    logic [CHANNELS-1:0] rep;
    logic [CNT_W-1:0]    cnt  [CHANNELS];
    logic [HOLD_W-1:0]   hcnt [CHANNELS];

    logic [CHANNELS-1:0] settle;
    logic [CHANNELS-1:0] key_next;
    logic [CHANNELS-1:0] saturated;
    logic [CHANNELS-1:0] fire;

    // Normalise the pin polarity so that 1 always means pressed.
    assign raw = bus.key_i ^ INV_MASK;

    // Next debounced level and hold-target detection for every channel.
    always_comb begin
        settle    = '0;
        key_next  = '0;
        saturated = '0;
        fire      = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            // The candidate has been stable for the full count: key_o may take it.
            settle[ch]    = (s2[ch] == cand[ch]) && (cnt[ch] == STABLE_C);
            key_next[ch]  = settle[ch] ? cand[ch] : key_q[ch];
            // A single-shot hold that already fired parks hcnt at HOLD_C.
            saturated[ch] = !rep[ch] && (hcnt[ch] == HOLD_C);
            // This tick's increment would reach the current phase's target.
            fire[ch]      = bus.tick && key_q[ch] && !press_q[ch] && !saturated[ch]
                            && (hcnt[ch] == ((rep[ch] ? REPEAT_C : HOLD_C) - ONE_H));
        end
    end

    // Synchroniser, stability counter, debounced level and edge strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            cand      <= '0;
            key_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                cnt[ch] <= '0;
            end
        end else begin
            s1        <= raw;
            s2        <= s1;
            key_q     <= key_next;
            press_q   <= key_next & ~key_q;
            release_q <= ~key_next & key_q;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (s2[ch] != cand[ch]) begin
                    cand[ch] <= s2[ch];
                    cnt[ch]  <= '0;
                end else if (bus.tick && cnt[ch] != STABLE_C) begin
                    cnt[ch] <= cnt[ch] + ONE_C;
                end
            end
        end
    end

    // Long-press timer: first strobe after HOLD_CYCLES, then optional repeats.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep    <= '0;
            hold_q <= '0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                hcnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (!key_q[ch] || press_q[ch]) begin
                    hcnt[ch]   <= '0;
                    rep[ch]    <= 1'b0;
                    hold_q[ch] <= 1'b0;
                end else begin
                    // A release that lands on a hold target suppresses the strobe.
                    hold_q[ch] <= fire[ch] && key_next[ch];
                    if (fire[ch]) begin
                        if (REPEAT_CYCLES != 0) begin
                            hcnt[ch] <= '0;
                            rep[ch]  <= 1'b1;
                        end else begin
                            hcnt[ch] <= HOLD_C;
                        end
                    end else if (bus.tick && !saturated[ch]) begin
                        hcnt[ch] <= hcnt[ch] + ONE_H;
                    end
                end
            end
        end
    end

    assign bus.key_o     = key_q;
    assign bus.press_p   = press_q;
    assign bus.release_p = release_q;
    assign bus.hold_p    = hold_q;

endmodule
